// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage and 32x32 general-purpose register file.
//
// Captures an execute unit's result on the rising edge of 'finished' and
// commits it to the GPR that dst_type selects one cycle later. It also
// supplies two operand read ports that bypass the pending write, and a
// debug read port that shows committed state only.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active-high
//   finished  in   execute-unit done level
//   dst_type  in   destination select (DST_NONE/DST_RD/DST_RT/DST_RA)
//   rd, rt    in   destination fields of the current instruction
//   res       in   execute result
//   rs_addr   in   operand read port A index
//   rt_addr   in   operand read port B index
//   dbg_addr  in   debug read index
//   rs_data   out  port A data (bypasses the pending write)
//   rt_data   out  port B data (bypasses the pending write)
//   dbg_data  out  debug data (committed value only)
//   wb_busy   out  high while a captured result is pending write
//   wb_done   out  one-cycle pulse in the cycle the write commits
//   wb_count  out  number of committed non-discarded writes (wraps)
module wb_regfile #(
  parameter int unsigned DW   = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned CNTW = 16,
  parameter int unsigned DTW  = 2,
  parameter logic [DTW-1:0] DST_NONE = DTW'(0),
  parameter logic [DTW-1:0] DST_RD   = DTW'(1),
  parameter logic [DTW-1:0] DST_RT   = DTW'(2),
  parameter logic [DTW-1:0] DST_RA   = DTW'(3)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            finished,
  input  logic [DTW-1:0]  dst_type,
  input  logic [AW-1:0]   rd,
  input  logic [AW-1:0]   rt,
  input  logic [DW-1:0]   res,
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  input  logic [AW-1:0]   dbg_addr,
  output logic [DW-1:0]   rs_data,
  output logic [DW-1:0]   rt_data,
  output logic [DW-1:0]   dbg_data,
  output logic            wb_busy,
  output logic            wb_done,
  output logic [CNTW-1:0] wb_count
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [DW-1:0]   r_gpr [2**AW];
  logic [0:0]      r_state;
  logic            r_fin_q;
  logic [DW-1:0]   r_wdata;
  logic [AW-1:0]   r_widx;
  logic            r_wvalid;
  logic [CNTW-1:0] r_count;

  logic            w_start;
  logic [AW-1:0]   w_idx;
  logic            w_valid;
  logic            w_wr_now;

  // A level held high yields a single start; the edge is only honoured in IDLE.
  assign w_start  = finished & ~r_fin_q;
  assign w_wr_now = (r_state == S_WRITE) & r_wvalid;

  // Destination decode; $0 targets are discarded like DST_NONE.
  always_comb begin
    w_idx   = '0;
    w_valid = 1'b0;
    case (dst_type)
      DST_RD: begin
        w_idx   = rd;
        w_valid = 1'b1;
      end
      DST_RT: begin
        w_idx   = rt;
        w_valid = 1'b1;
      end
      DST_RA: begin
        w_idx   = '1;
        w_valid = 1'b1;
      end
      default: begin
        w_idx   = '0;
        w_valid = 1'b0;
      end
    endcase
    if (w_idx == '0) begin
      w_valid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpr    <= '{default: '0};
      r_state  <= S_IDLE;
      r_fin_q  <= 1'b0;
      r_wdata  <= '0;
      r_widx   <= '0;
      r_wvalid <= 1'b0;
      r_count  <= '0;
    end else begin
      r_fin_q <= finished;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_wdata  <= res;
            r_widx   <= w_idx;
            r_wvalid <= w_valid;
            r_state  <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (r_wvalid) begin
            r_gpr[r_widx] <= r_wdata;
            r_count       <= r_count + CNTW'(1);
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand ports forward the pending write so the next instruction sees it
  // without waiting for the commit.
  always_comb begin
    rs_data = r_gpr[rs_addr];
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if (w_wr_now && (rs_addr == r_widx)) begin
      rs_data = r_wdata;
    end
  end

  always_comb begin
    rt_data = r_gpr[rt_addr];
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if (w_wr_now && (rt_addr == r_widx)) begin
      rt_data = r_wdata;
    end
  end

  always_comb begin
    dbg_data = r_gpr[dbg_addr];
    if (dbg_addr == '0) begin
      dbg_data = '0;
    end
  end

  assign wb_busy  = (r_state == S_WRITE);
  assign wb_done  = (r_state == S_WRITE);
  assign wb_count = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile -- scoreboard bench for wb_regfile.
// Stimulus keeps an array model of the register file, pushes the expected
// response of every writeback into a queue, and a negedge monitor pops and
// compares whenever the DUT pulses wb_done. The counter width is reduced so
// the wrap-around can be reached in a short run.
module tb_wb_regfile;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned CNTW = 8;
  localparam logic [1:0] D_NONE = 2'd0;
  localparam logic [1:0] D_RD   = 2'd1;
  localparam logic [1:0] D_RT   = 2'd2;
  localparam logic [1:0] D_RA   = 2'd3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            finished = 1'b0;
  logic [1:0]      dst_type = D_NONE;
  logic [AW-1:0]   rd = '0;
  logic [AW-1:0]   rt = '0;
  logic [DW-1:0]   res = '0;
  logic [AW-1:0]   rs_addr = '0;
  logic [AW-1:0]   rt_addr = '0;
  logic [AW-1:0]   dbg_addr = '0;
  logic [DW-1:0]   rs_data;
  logic [DW-1:0]   rt_data;
  logic [DW-1:0]   dbg_data;
  logic            wb_busy;
  logic            wb_done;
  logic [CNTW-1:0] wb_count;

  wb_regfile #(
    .DW(DW), .AW(AW), .CNTW(CNTW), .DTW(2),
    .DST_NONE(D_NONE), .DST_RD(D_RD), .DST_RT(D_RT), .DST_RA(D_RA)
  ) dut (
    .clk(clk), .rst(rst), .finished(finished), .dst_type(dst_type),
    .rd(rd), .rt(rt), .res(res),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .dbg_addr(dbg_addr),
    .rs_data(rs_data), .rt_data(rt_data), .dbg_data(dbg_data),
    .wb_busy(wb_busy), .wb_done(wb_done), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] rd_exp;
    logic [DW-1:0] dbg_exp;
    int unsigned   cnt_before;
    int unsigned   cnt_after;
    bit            abort;
  } item_t;

  item_t       q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: plain array plus a modulo counter.
  logic [DW-1:0] mem [32];
  int unsigned   cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare on the wb_done cycle, then the committed view one cycle later.
  item_t cur;
  bit    post_pending = 0;
  always @(negedge clk) begin
    if (post_pending) begin
      post_pending = 0;
      chk("dbg_after_commit", dbg_data, cur.dbg_exp);
      chk("count_after_commit", 32'(wb_count), cur.cnt_after);
      chk("busy_after_commit", 32'(wb_busy), 32'd0);
      chk("done_one_cycle", 32'(wb_done), 32'd0);
    end
    if (wb_done === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_wb_done: got 1 expected 0 (no writeback pending)");
      end else begin
        cur = q.pop_front();
        chk("rs_bypass", rs_data, cur.rd_exp);
        chk("rt_bypass", rt_data, cur.rd_exp);
        chk("busy_in_write", 32'(wb_busy), 32'd1);
        chk("count_in_write", 32'(wb_count), cur.cnt_before);
        if (!cur.abort) post_pending = 1;
      end
    end
  end

  function automatic logic [AW-1:0] target(input logic [1:0] dt,
                                          input logic [AW-1:0] a_rd,
                                          input logic [AW-1:0] a_rt);
    case (dt)
      D_RT:    return a_rt;
      D_RA:    return 5'd31;
      default: return a_rd;
    endcase
  endfunction

  // One writeback: finished high for 'hold' cycles, then low for gap+1 cycles.
  task automatic op(input logic [1:0] dt, input logic [AW-1:0] a_rd,
                    input logic [AW-1:0] a_rt, input logic [DW-1:0] r,
                    input int unsigned hold, input int unsigned gap);
    item_t         it;
    logic [AW-1:0] t;
    bit            v;
    t = target(dt, a_rd, a_rt);
    v = (dt != D_NONE) && (t != 0);
    it.addr       = t;
    it.cnt_before = cnt;
    if (v) begin
      mem[t] = r;
      cnt    = (cnt + 1) % (1 << CNTW);
    end
    it.rd_exp    = (t == 0) ? '0 : mem[t];
    it.dbg_exp   = it.rd_exp;
    it.cnt_after = cnt;
    it.abort     = 0;
    q.push_back(it);
    @(posedge clk); #1;
    dst_type = dt; rd = a_rd; rt = a_rt; res = r;
    rs_addr = t; rt_addr = t; dbg_addr = t;
    finished = 1'b1;
    repeat (hold) @(posedge clk);
    #1 finished = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state sweep.
    for (int i = 0; i < 32; i++) begin
      dbg_addr = AW'(i);
      @(negedge clk);
      chk("reset_dbg", dbg_data, 32'd0);
    end
    chk("reset_count", 32'(wb_count), 32'd0);
    chk("reset_busy", 32'(wb_busy), 32'd0);
    chk("reset_done", 32'(wb_done), 32'd0);

    // Directed cases.
    op(D_RD, 5'd5, 5'd0, 32'hDEADBEEF, 1, 3);
    op(D_RT, 5'd0, 5'd9, 32'h7, 6, 3);
    op(D_RD, 5'd0, 5'd3, 32'h1234, 1, 3);
    op(D_NONE, 5'd12, 5'd4, 32'h1234, 2, 3);
    op(D_RA, 5'd1, 5'd2, 32'h00400010, 1, 3);

    // Back-to-back writes to $31 pushing the counter through its wrap point.
    for (int i = 0; i < (1 << CNTW) + 4; i++) begin
      op(D_RA, 5'd0, 5'd0, $urandom, 1, 0);
    end
    repeat (3) @(posedge clk);

    // Randomized mix of destinations, hold lengths and gaps.
    for (int i = 0; i < 80; i++) begin
      op(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
         $urandom, $urandom_range(1, 6), $urandom_range(2, 3));
    end

    // Reset during the WRITE cycle abandons the pending write.
    begin
      item_t it;
      it.addr = 5'd7; it.rd_exp = 32'hCAFEF00D; it.dbg_exp = '0;
      it.cnt_before = cnt; it.cnt_after = 0; it.abort = 1;
      q.push_back(it);
      @(posedge clk); #1;
      dst_type = D_RD; rd = 5'd7; res = 32'hCAFEF00D;
      rs_addr = 5'd7; rt_addr = 5'd7; dbg_addr = 5'd7;
      finished = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; finished = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      cnt = 0;
      @(negedge clk);
      chk("abort_gpr7", dbg_data, 32'd0);
      chk("abort_count", 32'(wb_count), 32'd0);
      chk("abort_busy", 32'(wb_busy), 32'd0);
      dbg_addr = 5'd31;
      @(negedge clk);
      chk("abort_gpr31", dbg_data, 32'd0);
    end

    // A write after the abort still works from a cleared counter.
    op(D_RD, 5'd7, 5'd0, 32'h55AA55AA, 2, 3);
    repeat (4) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
